// File: rtl/csr_seq_pkg.sv
// csr_seq_pkg: scratchpad target table, test pattern and FSM states for csr_scratch_seq
package csr_seq_pkg;
  localparam int NUM_TGT = 5;
  localparam logic [63:0] PAT_BASE = 64'hA5A5_5A5A_0000_0000;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  pf;
    logic [10:0] vf;
    logic        va;
  } tgt_t;
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, CHECK, NEXT, FIN} state_t;
  function automatic tgt_t mk_tgt(input logic [31:0] addr, input logic [2:0] pf);
    mk_tgt = '{addr: addr, pf: pf, vf: 11'd0, va: 1'b0};
  endfunction
  // Entry 0 is the LSB element: FME, PCIE, VIRTIO, HSSI, HE-LB
  localparam tgt_t [NUM_TGT-1:0] TGT_TABLE = {
    mk_tgt(32'h0000_0100, 3'd1),
    mk_tgt(32'h0006_0030, 3'd0),
    mk_tgt(32'h0002_0018, 3'd0),
    mk_tgt(32'h0001_0008, 3'd0),
    mk_tgt(32'h0000_0028, 3'd0)
  };
endpackage

// File: rtl/csr_seq_timeout.sv
// csr_seq_timeout: read-response watchdog; expired flags the last allowed cycle of a wait
module csr_seq_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = en && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/csr_scratch_seq.sv
// csr_scratch_seq: writes then reads back a pattern on every scratch CSR in two passes
module csr_scratch_seq
  import csr_seq_pkg::*;
#(
  parameter int NUM_TGT = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_cnt,
  output logic [NUM_TGT-1:0] err_mask,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [31:0]        req_addr,
  output logic [2:0]         req_pf,
  output logic [10:0]        req_vf,
  output logic               req_vf_active,
  output logic [63:0]        req_wdata,
  input  logic               rsp_valid,
  input  logic [63:0]        rsp_data
);
  localparam int IW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic phase, phase_n, miss, last, hs, expired, issue, load;
  logic [63:0] pat;
  tgt_t tgt;
  assign hs = req_valid && req_ready;
  assign last = idx == IW'(NUM_TGT - 1);
  assign idx_n = (state == NEXT) ? (last ? '0 : idx + 1'b1) : idx;
  assign phase_n = phase ^ (state == NEXT && last);
  // Request fields are loaded from the upcoming target so they are valid with req_valid
  assign tgt = TGT_TABLE[idx_n];
  assign pat = (PAT_BASE | 64'(idx_n)) ^ {64{phase_n}};
  assign busy = state != IDLE && state != FIN;
  assign done = state == FIN;
  assign issue = state_n == WR_REQ || state_n == RD_REQ;
  assign load = issue && state_n != state;
  csr_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == RD_REQ && hs),
    .en(state == RD_WAIT),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? WR_REQ : IDLE;
      WR_REQ:  state_n = hs ? RD_REQ : WR_REQ;
      RD_REQ:  state_n = hs ? RD_WAIT : RD_REQ;
      RD_WAIT: state_n = (rsp_valid || expired) ? CHECK : RD_WAIT;
      CHECK:   state_n = NEXT;
      NEXT:    state_n = (phase && last) ? FIN : WR_REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      phase <= 1'b0;
      miss <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      err_mask <= '0;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr <= '0;
      req_pf <= '0;
      req_vf <= '0;
      req_vf_active <= 1'b0;
      req_wdata <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      phase <= phase_n;
      req_valid <= issue;
      if (load) begin
        req_write <= state_n == WR_REQ;
        req_addr <= tgt.addr;
        req_pf <= tgt.pf;
        req_vf <= tgt.vf;
        req_vf_active <= tgt.va;
        req_wdata <= pat;
      end
      // A response coinciding with expiry wins; expiry alone counts as a miss
      if (state == RD_WAIT) miss <= !rsp_valid || rsp_data != pat;
      if (state == CHECK && miss) begin
        err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
        err_mask[idx] <= 1'b1;
      end
      if (state == IDLE && start) begin
        err_cnt <= '0;
        err_mask <= '0;
        pass <= 1'b0;
      end
      if (state_n == FIN) pass <= err_cnt == '0;
    end
  end
endmodule

// File: tb/tb_csr_scratch_seq.sv
// tb_csr_scratch_seq: directed scenarios against a memory-backed CSR responder
module tb_csr_scratch_seq;
  import csr_seq_pkg::*;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy, done, pass, req_valid, req_write, req_vf_active;
  logic [7:0] err_cnt;
  logic [4:0] err_mask;
  logic [31:0] req_addr;
  logic [2:0] req_pf;
  logic [10:0] req_vf;
  logic [63:0] req_wdata;
  logic req_ready = 0, rsp_valid = 0;
  logic [63:0] rsp_data = '0;
  int checks = 0, errors = 0;
  logic ready_rand = 0, zero_helb = 0, drop_pcie = 0;
  int lat = 2, inj_req = 0;
  int cyc = 0, inj_done = 0, rd_cnt = 0, done_cnt = 0, stab_err = 0, ai = 0;
  logic [63:0] rd_data = '0;
  logic [63:0] mem [5];
  logic [111:0] cur, p_f = '0;
  logic p_valid = 0, p_ready = 0;
  logic [31:0] l_addr[$];
  logic l_wr[$], l_va[$];
  logic [2:0] l_pf[$];
  logic [10:0] l_vf[$];
  logic [63:0] l_wd[$];
  int l_cyc[$];
  logic [31:0] exp_addr [5] = '{32'h28, 32'h10008, 32'h20018, 32'h60030, 32'h100};
  logic [2:0] exp_pf [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

  csr_scratch_seq #(.NUM_TGT(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .err_mask(err_mask), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_pf(req_pf), .req_vf(req_vf),
    .req_vf_active(req_vf_active), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic int a2i(input logic [31:0] a);
    for (int i = 0; i < 5; i++) if (exp_addr[i] == a) return i;
    return 0;
  endfunction

  function automatic logic [63:0] epat(input int p, input int i);
    logic [63:0] v;
    v = 64'hA5A5_5A5A_0000_0000 | 64'(i);
    return (p != 0) ? ~v : v;
  endfunction

  // Responder and bus monitor; decisions made here take effect at the next rising edge
  always @(negedge clk) begin
    cyc++;
    cur = {req_write, req_addr, req_pf, req_vf, req_vf_active, req_wdata};
    if (rst_n && p_valid && !p_ready && (!req_valid || cur != p_f)) stab_err++;
    if (done) done_cnt++;
    rsp_valid = 0;
    if (inj_req != inj_done) begin
      inj_done = inj_req;
      rsp_valid = 1;
      rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rsp_valid = 1;
        rsp_data = rd_data;
      end
    end
    req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && req_valid && req_ready) begin
      l_addr.push_back(req_addr);
      l_wr.push_back(req_write);
      l_pf.push_back(req_pf);
      l_vf.push_back(req_vf);
      l_va.push_back(req_vf_active);
      l_wd.push_back(req_wdata);
      l_cyc.push_back(cyc);
      ai = a2i(req_addr);
      if (req_write) mem[ai] = req_wdata;
      else if (!(drop_pcie && ai == 1)) begin
        rd_cnt = lat;
        rd_data = (zero_helb && ai == 4) ? 64'd0 : mem[ai];
      end
    end
    p_valid = req_valid;
    p_ready = req_ready;
    p_f = cur;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse;
    tick();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done;
    bit found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL done_timeout: done never seen within 3000 cycles, busy=%b", busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if ({busy, done, pass, err_cnt, err_mask, req_valid, req_write, req_addr, req_pf, req_vf, req_vf_active, req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b err_cnt=%0d err_mask=%b req_valid=%b req_write=%b req_addr=%h req_pf=%0d req_vf=%0d va=%b wdata=%h, expected all 0",
               busy, done, pass, err_cnt, err_mask, req_valid, req_write, req_addr, req_pf, req_vf, req_vf_active, req_wdata);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected IDLE", dut.state);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_echo;
    int b, d0, bad, p, i;
    bit wr;
    b = l_addr.size();
    d0 = done_cnt;
    start_pulse();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL echo_busy_after_start: got %b expected 1", busy);
    end
    wait_done();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL echo_busy_with_done: got %b expected 0", busy);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || err_mask !== 5'd0) begin
      errors++;
      $display("FAIL echo_result: pass=%b err_cnt=%0d err_mask=%b expected 1/0/00000", pass, err_cnt, err_mask);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL echo_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (l_addr.size() - b != 20) begin
      errors++;
      $display("FAIL echo_req_count: got %0d expected 20", l_addr.size() - b);
    end
    bad = 0;
    for (int j = 0; j < 20 && b + j < l_addr.size(); j++) begin
      p = j / 10;
      i = (j % 10) / 2;
      wr = (j % 2) == 0;
      if (l_addr[b+j] != exp_addr[i] || l_wr[b+j] != wr || l_pf[b+j] != exp_pf[i] ||
          l_vf[b+j] != 11'd0 || l_va[b+j] != 1'b0 || (wr && l_wd[b+j] != epat(p, i))) begin
        bad++;
        if (bad <= 3)
          $display("  request %0d: addr=%h wr=%b pf=%0d wdata=%h, expected addr=%h wr=%b pf=%0d wdata=%h",
                   j, l_addr[b+j], l_wr[b+j], l_pf[b+j], l_wd[b+j], exp_addr[i], wr, exp_pf[i], epat(p, i));
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL echo_req_order: got %0d bad requests expected 0", bad);
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL echo_pass_held: pass=%b busy=%b expected 1/0", pass, busy);
    end
  endtask

  task automatic test_helb;
    zero_helb = 1;
    start_pulse();
    wait_done();
    checks++;
    if (pass !== 1'b0 || err_cnt !== 8'd2 || err_mask !== 5'b10000) begin
      errors++;
      $display("FAIL helb_result: pass=%b err_cnt=%0d err_mask=%b expected 0/2/10000", pass, err_cnt, err_mask);
    end
    zero_helb = 0;
    tick();
  endtask

  task automatic test_random_ready;
    int b, s0;
    b = l_addr.size();
    s0 = stab_err;
    ready_rand = 1;
    start_pulse();
    checks++;
    if (err_cnt !== 8'd0 || err_mask !== 5'd0 || pass !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clears: err_cnt=%0d err_mask=%b pass=%b busy=%b expected 0/00000/0/1", err_cnt, err_mask, pass, busy);
    end
    wait_done();
    ready_rand = 0;
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || err_mask !== 5'd0) begin
      errors++;
      $display("FAIL rand_result: pass=%b err_cnt=%0d err_mask=%b expected 1/0/00000", pass, err_cnt, err_mask);
    end
    checks++;
    if (l_addr.size() - b != 20) begin
      errors++;
      $display("FAIL rand_req_count: got %0d expected 20", l_addr.size() - b);
    end
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL rand_stability: got %0d unstable stalls expected 0", stab_err - s0);
    end
    tick();
  endtask

  task automatic test_timeout;
    int b, k, gap;
    b = l_addr.size();
    drop_pcie = 1;
    start_pulse();
    wait_done();
    drop_pcie = 0;
    checks++;
    if (pass !== 1'b0 || err_cnt !== 8'd2 || err_mask !== 5'b00010) begin
      errors++;
      $display("FAIL timeout_result: pass=%b err_cnt=%0d err_mask=%b expected 0/2/00010", pass, err_cnt, err_mask);
    end
    k = -1;
    for (int j = b; j < l_addr.size() - 1; j++)
      if (k < 0 && l_addr[j] == 32'h10008 && !l_wr[j]) k = j;
    gap = (k < 0) ? -1 : l_cyc[k+1] - l_cyc[k];
    // 16 RD_WAIT cycles, then CHECK, NEXT and the registered write request
    checks++;
    if (gap != TO + 3) begin
      errors++;
      $display("FAIL timeout_length: got %0d cycles read-to-next-request expected %0d", gap, TO + 3);
    end
    tick();
  endtask

  task automatic test_timeout_edge;
    lat = TO;
    start_pulse();
    wait_done();
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rsp_at_expiry: pass=%b err_cnt=%0d expected 1/0", pass, err_cnt);
    end
    lat = TO + 1;
    start_pulse();
    wait_done();
    checks++;
    if (pass !== 1'b0 || err_cnt !== 8'd10 || err_mask !== 5'b11111) begin
      errors++;
      $display("FAIL rsp_after_expiry: pass=%b err_cnt=%0d err_mask=%b expected 0/10/11111", pass, err_cnt, err_mask);
    end
    lat = 2;
    tick();
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    int b, d0;
    lat = 4;
    start_pulse();
    for (int i = 0; i < 500; i++) begin
      if (l_addr.size() > 0 && l_addr[$] == 32'h20018 && !l_wr[$]) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_no_read: target 2 read not seen expected 1");
    end
    tick();
    checks++;
    if (dut.state !== RD_WAIT) begin
      errors++;
      $display("FAIL rstmid_in_rd_wait: got %0d expected RD_WAIT", dut.state);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    d0 = done_cnt;
    checks++;
    if ({busy, done, pass, err_cnt, err_mask, req_valid, req_write, req_addr, req_pf, req_vf, req_vf_active, req_wdata} !== '0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b pass=%b err_cnt=%0d req_valid=%b req_addr=%h state=%0d expected all 0/IDLE",
               busy, pass, err_cnt, req_valid, req_addr, dut.state);
    end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || req_valid !== 1'b0 || err_cnt !== 8'd0 || done_cnt != d0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL rstmid_late_rsp: busy=%b req_valid=%b err_cnt=%0d done_pulses=%0d state=%0d expected 0/0/0/0/IDLE",
               busy, req_valid, err_cnt, done_cnt - d0, dut.state);
    end
    b = l_addr.size();
    start_pulse();
    wait_done();
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || l_addr.size() - b != 20) begin
      errors++;
      $display("FAIL rstmid_rerun: pass=%b err_cnt=%0d reqs=%0d expected 1/0/20", pass, err_cnt, l_addr.size() - b);
    end
    lat = 2;
    tick();
  endtask

  task automatic test_start_busy;
    int b, d0;
    inj_req++;
    repeat (2) tick();
    checks++;
    if (err_cnt !== 8'd0 || busy !== 1'b0 || pass !== 1'b1 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL idle_rsp_ignored: err_cnt=%0d busy=%b pass=%b state=%0d expected 0/0/1/IDLE", err_cnt, busy, pass, dut.state);
    end
    b = l_addr.size();
    d0 = done_cnt;
    start_pulse();
    repeat (5) tick();
    start = 1;
    tick();
    start = 0;
    wait_done();
    repeat (30) tick();
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || err_mask !== 5'd0) begin
      errors++;
      $display("FAIL busy_start_result: pass=%b err_cnt=%0d err_mask=%b expected 1/0/00000", pass, err_cnt, err_mask);
    end
    checks++;
    if (l_addr.size() - b != 20 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: reqs=%0d done_pulses=%0d busy=%b expected 20/1/0", l_addr.size() - b, done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_helb();
    test_random_ready();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/csr_scratch_seq.md
CSR_SCRATCH_SEQ -- requirements
Module: csr_scratch_seq

Interface
REQ-001 SHALL have parameter NUM_TGT, default 5, number of scratchpad targets in the package table.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for a read response.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a sequence.
REQ-006 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-007 SHALL have port done, output, 1, a one-cycle pulse at sequence end.
REQ-008 SHALL have port pass, output, 1, high when the last sequence had zero errors; held until the next start.
REQ-009 SHALL have port err_cnt, output, 8, saturating count of failing reads in the current or last sequence.
REQ-010 SHALL have port err_mask, output, NUM_TGT, sticky per-target failure bits.
REQ-011 SHALL have port req_valid/req_ready, output/input, 1/1, request handshake.
REQ-012 SHALL have port req_write, output, 1; 1 means write, 0 means read.
REQ-013 SHALL have port req_addr, output, 32, CSR byte address.
REQ-014 SHALL have ports req_pf (3), req_vf (11) and req_vf_active (1), all outputs, giving function routing.
REQ-015 SHALL have port req_wdata, output, 64, write data.
REQ-016 SHALL have ports rsp_valid (1) and rsp_data (64), both inputs, carrying read completion. There is no backpressure on this channel.

Function
REQ-017 Targets SHALL be indexed 0..NUM_TGT-1 in this order, with the following address, PF, VF and VF-active values:
- FME scratch: 0x28, PF0, VF0, VF-active 0.
- PCIE scratch: 0x10008, PF0, VF0, VF-active 0.
- VIRTIO scratch: 0x20018, PF0, VF0, VF-active 0.
- HSSI rcfg_data: 0x60030, PF0, VF0, VF-active 0.
- HE-LB scratch: 0x100, PF1, VF0, VF-active 0.
REQ-018 Each sequence SHALL run two passes.
- Pass 0 pattern: 64'hA5A5_5A5A_0000_0000 | idx.
- Pass 1 pattern: the bitwise inverse of the pass 0 pattern.
REQ-019 For each pass, and each target in index order, the block SHALL write the pattern, then read the same target and compare the result.
REQ-020 The state machine SHALL use these states:
- IDLE
- WR_REQ
- RD_REQ
- RD_WAIT
- CHECK
- NEXT
- FIN
REQ-021 State transitions SHALL be:
- IDLE->WR_REQ on start.
- WR_REQ->RD_REQ on handshake.
- RD_REQ->RD_WAIT on handshake.
- RD_WAIT->CHECK on rsp_valid or on timeout.
- CHECK->NEXT.
- NEXT->WR_REQ, or NEXT->FIN after the last target of pass 1.
- FIN->IDLE.
REQ-022 All req_* outputs SHALL be registered.
REQ-023 req_valid, once asserted, SHALL hold until req_valid&&req_ready, and all req_* fields SHALL stay stable while req_valid is high.
REQ-024 Writes SHALL be posted: no response is expected after a write.
REQ-025 A handshake in state S SHALL deassert req_valid on the next cycle unless the next state also issues a request.
REQ-026 rsp_valid SHALL be sampled only in RD_WAIT; outside RD_WAIT it is ignored.
REQ-027 A mismatch between rsp_data and the pattern SHALL increment err_cnt (saturating at 255) and set err_mask[idx].
REQ-028 The RD_WAIT timeout counter SHALL clear on entry to RD_WAIT.
REQ-029 If TIMEOUT cycles elapse in RD_WAIT without rsp_valid, the read SHALL be treated as a mismatch and the sequence SHALL continue.
REQ-030 When rsp_valid arrives in the same cycle the timeout expires, it SHALL be treated as a response, not a timeout.
REQ-031 start SHALL clear err_cnt, err_mask and pass, then assert busy on the next cycle.
REQ-032 start while busy SHALL be ignored.
REQ-033 In FIN, done SHALL pulse for one cycle, pass SHALL be set to (err_cnt==0), and busy SHALL drop on the same cycle done is high.
REQ-034 req_ready held low indefinitely SHALL stall the sequence without a timeout; the timeout applies only in RD_WAIT.

Reset
REQ-035 On rst_n low at a rising edge, the state SHALL return to IDLE and these outputs SHALL be 0: busy, done, pass, err_cnt, err_mask, req_valid, and all req_* fields.
REQ-036 Reset mid-sequence SHALL abandon any outstanding request with no further output activity; a late rsp_valid after reset is ignored.

Structure
REQ-037 Package csr_seq_pkg SHALL hold:
- the target struct (addr, pf, vf, va);
- the NUM_TGT constant;
- the target table constant;
- the pattern base constant;
- the state enum.
REQ-038 The timeout counter SHALL be a sub-module, csr_seq_timeout, with inputs clr and en, and output expired.

Verification
REQ-039 Responder echoing written data, req_ready always 1, start pulse -> 20 requests in order, done pulse once, pass=1, err_cnt=0, err_mask=0.
REQ-040 Responder returns 0 for HE-LB (addr 0x100) only -> pass=0, err_cnt=2, err_mask=5'b10000.
REQ-041 req_ready toggled randomly at 50% -> req_* fields stable while req_valid && !req_ready, and final result identical to REQ-039.
REQ-042 No response to the PCIE read, TIMEOUT=16 -> RD_WAIT exits after 16 cycles, err_mask[1]=1, sequence completes with err_cnt=2.
REQ-043 rst_n low during RD_WAIT of target 2, then rsp_valid 3 cycles later -> all outputs 0, state IDLE, late response ignored; a new start completes with pass=1.
REQ-044 Second start during busy, plus rsp_valid injected while in IDLE -> no effect on the sequence or on err_cnt.
